// File: rtl/serial_defs.sv
// Shared serial-line definitions: receiver/sender state encodings, frame defaults, mid-sample point.
package serial_defs;
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } rx_state_t;

    localparam int DEFAULT_SAMPLE_RATIO = 16;
    localparam int DEFAULT_DATA_BITS    = 8;
    localparam int MID_SAMPLE           = DEFAULT_SAMPLE_RATIO / 2;

    function automatic int mid_sample(input int ratio);
        return ratio / 2;
    endfunction
endpackage

// File: rtl/din_synchronizer.sv
// Two-flop synchronizer for an asynchronous pin, both stages reset to the idle-high level.
// Latency: 2 clk; no backpressure.
module din_synchronizer (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);
    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
        end
    end

    assign dout = sync_q;
endmodule

// File: rtl/oversampled_receiver.sv
// Oversampling serial receiver, 8N1 (8E1 when RX_PARITY_EN is defined), majority-of-3 bit decisions.
// Latency: 2 clk sync + stop-bit mid-sample; no backpressure, valid/frame_err are one-cycle strobes.
module oversampled_receiver
    import serial_defs::*;
#(
    parameter int SAMPLE_RATIO = DEFAULT_SAMPLE_RATIO,
    parameter int DATA_BITS    = DEFAULT_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 din,
    input  logic                 sample_tick,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 busy,
    output logic                 frame_err
`ifdef RX_PARITY_EN
    ,
    output logic                 parity_err
`endif
);
    localparam int CNT_W = $clog2(SAMPLE_RATIO);
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam int M     = mid_sample(SAMPLE_RATIO);

    localparam logic [CNT_W-1:0] C_LO   = CNT_W'(M - 1);
    localparam logic [CNT_W-1:0] C_MID  = CNT_W'(M);
    localparam logic [CNT_W-1:0] C_DEC  = CNT_W'(M + 1);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(SAMPLE_RATIO - 1);
    localparam logic [BIT_W-1:0] B_LAST = BIT_W'(DATA_BITS - 1);

    logic rx;

    din_synchronizer u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (din),
        .dout (rx)
    );

    rx_state_t            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [1:0]           samp_q, samp_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 busy_q, busy_d;
    logic                 frame_err_q, frame_err_d;
`ifdef RX_PARITY_EN
    logic                 par_q, par_d;
    logic                 parity_err_q, parity_err_d;
`endif

    logic [CNT_W-1:0] cnt_inc;
    logic             decision;

    always_comb begin
        cnt_inc  = (cnt_q == C_LAST) ? '0 : cnt_q + CNT_W'(1);
        // Third sample is the live rx at the decision count.
        decision = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx) | (samp_q[1] & rx);

        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        samp_d      = samp_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        frame_err_d = 1'b0;
`ifdef RX_PARITY_EN
        par_d        = par_q;
        parity_err_d = 1'b0;
`endif

        if (sample_tick) begin
            if (state_q != IDLE && state_q != BREAK) begin
                cnt_d = cnt_inc;
                if (cnt_q == C_LO)  samp_d[0] = rx;
                if (cnt_q == C_MID) samp_d[1] = rx;
            end

            case (state_q)
                IDLE: begin
                    if (!rx) begin
                        state_d = START;
                        cnt_d   = CNT_W'(1);
                    end
                end
                START: begin
                    if (cnt_q == C_DEC && decision) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == C_LAST) begin
                        state_d   = DATA;
                        bit_idx_d = '0;
                    end
                end
                DATA: begin
                    if (cnt_q == C_DEC) shift_d = {decision, shift_q[DATA_BITS-1:1]};
                    if (cnt_q == C_LAST) begin
                        if (bit_idx_q == B_LAST) begin
`ifdef RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            bit_idx_d = bit_idx_q + BIT_W'(1);
                        end
                    end
                end
`ifdef RX_PARITY_EN
                PARITY: begin
                    if (cnt_q == C_DEC)  par_d   = decision;
                    if (cnt_q == C_LAST) state_d = STOP;
                end
`endif
                STOP: begin
                    // Leave mid-stop so the next start edge is never missed.
                    if (cnt_q == C_DEC) begin
                        cnt_d = '0;
                        if (decision) begin
                            state_d = IDLE;
                            data_d  = shift_q;
                            valid_d = 1'b1;
`ifdef RX_PARITY_EN
                            parity_err_d = ^{shift_q, par_q};
`endif
                        end else begin
                            state_d     = BREAK;
                            frame_err_d = 1'b1;
                        end
                    end
                end
                BREAK: begin
                    if (rx) state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            samp_q      <= 2'b11;
            data_q      <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef RX_PARITY_EN
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            samp_q      <= samp_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            frame_err_q <= frame_err_d;
`ifdef RX_PARITY_EN
            par_q        <= par_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign busy      = busy_q;
    assign frame_err = frame_err_q;
`ifdef RX_PARITY_EN
    assign parity_err = parity_err_q;
`endif
endmodule
